// File: rtl/ram_loader.sv
// Byte-stream RAM loader: packs incoming bytes little-endian into DATA_W words,
// writes them from a programmable start address and serves a registered read port.
module ram_loader #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   load_words,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   words_written,
  input  logic              rd_ena,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_dout
);
  localparam int BPW   = ((DATA_W - 1) / 8) + 1;
  localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int ASM_W = BPW * 8;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BPW - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     target_q, target_d;
  logic [ADDR_W:0]     words_q, words_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [ASM_W-1:0]    asm_q, asm_d;
  logic                in_ready_q, in_ready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   rd_dout_q;

  logic [ASM_W-1:0]    full_s;
  logic                wr_en_s;
  logic [DATA_W-1:0]   wr_data_s;
  logic [ADDR_W-1:0]   wr_addr_s;

  logic [DATA_W-1:0]   mem [0:(1<<ADDR_W)-1];

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    target_d = target_q;
    words_d  = words_q;
    idx_d    = idx_q;
    asm_d    = asm_q;
    wr_en_s  = 1'b0;
    full_s   = asm_q;
    full_s[ASM_W-1 -: 8] = in_data;

    case (state_q)
      IDLE: begin
        if (start) begin
          words_d = '0;
          idx_d   = '0;
          asm_d   = '0;
          if (load_words == '0) begin
            state_d = DONE;
          end else begin
            addr_d   = start_addr;
            target_d = load_words;
            state_d  = LOAD;
          end
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        // abort wins over a byte offered on the same edge
        if (abort) begin
          state_d = IDLE;
          idx_d   = '0;
          asm_d   = '0;
        end else if (in_valid && in_ready_q) begin
          if (idx_q == IDX_LAST) begin
            wr_en_s = 1'b1;
            idx_d   = '0;
            asm_d   = '0;
            addr_d  = addr_q + 1'b1;
            words_d = words_q + 1'b1;
            if (words_d == target_q) begin
              state_d = DONE;
            end else begin
              state_d = LOAD;
            end
          end else begin
            asm_d[{idx_q, 3'b000} +: 8] = in_data;
            idx_d = idx_q + 1'b1;
          end
        end else begin
          state_d = LOAD;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d == LOAD);
    busy_d     = (state_d == LOAD);
    done_d     = (state_d == DONE);
  end

  assign wr_data_s = full_s[DATA_W-1:0];
  assign wr_addr_s = addr_q;

  // Control and status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      target_q   <= '0;
      words_q    <= '0;
      idx_q      <= '0;
      asm_q      <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      target_q   <= target_d;
      words_q    <= words_d;
      idx_q      <= idx_d;
      asm_q      <= asm_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Storage array; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem[wr_addr_s] <= wr_data_s;
    end
  end

  // Read port register; a same-edge write is not visible until the next read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_dout_q <= '0;
    end else if (rd_ena) begin
      rd_dout_q <= mem[rd_addr];
    end else begin
      rd_dout_q <= rd_dout_q;
    end
  end

  assign in_ready      = in_ready_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign words_written = words_q;
  assign rd_dout       = rd_dout_q;

endmodule

// File: tb/tb_ram_loader.sv
// Directed bench for ram_loader: a 16-bit instance (a_*) and an 8-bit instance (b_*),
// both 16 words deep, sharing one clock and reset.
module tb_ram_loader;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        a_start, a_abort, a_in_valid, a_rd_ena, a_in_ready, a_busy, a_done;
  logic [3:0]  a_start_addr, a_rd_addr;
  logic [4:0]  a_load_words, a_words_written;
  logic [7:0]  a_in_data;
  logic [15:0] a_rd_dout;

  logic        b_start, b_abort, b_in_valid, b_rd_ena, b_in_ready, b_busy, b_done;
  logic [3:0]  b_start_addr, b_rd_addr;
  logic [4:0]  b_load_words, b_words_written;
  logic [7:0]  b_in_data;
  logic [7:0]  b_rd_dout;

  int checks = 0;
  int failures = 0;
  logic [7:0] pat [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
  logic [3:0] wrap_addr [4] = '{4'd14, 4'd15, 4'd0, 4'd1};

  ram_loader #(.ADDR_W(4), .DATA_W(16)) u_a (
    .clk(clk), .rst(rst), .start(a_start), .start_addr(a_start_addr),
    .load_words(a_load_words), .abort(a_abort), .in_valid(a_in_valid),
    .in_data(a_in_data), .in_ready(a_in_ready), .busy(a_busy), .done(a_done),
    .words_written(a_words_written), .rd_ena(a_rd_ena), .rd_addr(a_rd_addr),
    .rd_dout(a_rd_dout)
  );

  ram_loader #(.ADDR_W(4), .DATA_W(8)) u_b (
    .clk(clk), .rst(rst), .start(b_start), .start_addr(b_start_addr),
    .load_words(b_load_words), .abort(b_abort), .in_valid(b_in_valid),
    .in_data(b_in_data), .in_ready(b_in_ready), .busy(b_busy), .done(b_done),
    .words_written(b_words_written), .rd_ena(b_rd_ena), .rd_addr(b_rd_addr),
    .rd_dout(b_rd_dout)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic a_begin(input logic [3:0] sa, input logic [4:0] n);
    a_start = 1'b1;
    a_start_addr = sa;
    a_load_words = n;
    step();
    a_start = 1'b0;
  endtask

  task automatic a_send(input logic [7:0] b);
    a_in_valid = 1'b1;
    a_in_data = b;
    step();
    a_in_valid = 1'b0;
  endtask

  task automatic a_read(input logic [3:0] ad, input logic [15:0] exp, input string tag);
    a_rd_ena = 1'b1;
    a_rd_addr = ad;
    step();
    a_rd_ena = 1'b0;
    check(tag, 32'(a_rd_dout), 32'(exp));
  endtask

  initial begin
    rst = 1'b1;
    a_start = 1'b0; a_abort = 1'b0; a_in_valid = 1'b0; a_rd_ena = 1'b0;
    a_start_addr = 4'd0; a_rd_addr = 4'd0; a_load_words = 5'd0; a_in_data = 8'd0;
    b_start = 1'b0; b_abort = 1'b0; b_in_valid = 1'b0; b_rd_ena = 1'b0;
    b_start_addr = 4'd0; b_rd_addr = 4'd0; b_load_words = 5'd0; b_in_data = 8'd0;
    #12;
    check("rst_in_ready", 32'(a_in_ready), 32'd0);
    check("rst_busy", 32'(a_busy), 32'd0);
    check("rst_done", 32'(a_done), 32'd0);
    check("rst_words", 32'(a_words_written), 32'd0);
    check("rst_rd_dout", 32'(a_rd_dout), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();

    // basic packing, in_valid held high
    a_begin(4'd2, 5'd3);
    check("t1_busy", 32'(a_busy), 32'd1);
    check("t1_in_ready", 32'(a_in_ready), 32'd1);
    a_in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      a_in_data = pat[i];
      step();
      if (i == 4) check("t1_words_mid", 32'(a_words_written), 32'd2);
      if (i < 5) check("t1_no_done", 32'(a_done), 32'd0);
    end
    a_in_valid = 1'b0;
    check("t1_done", 32'(a_done), 32'd1);
    check("t1_words", 32'(a_words_written), 32'd3);
    check("t1_busy_end", 32'(a_busy), 32'd0);
    check("t1_in_ready_end", 32'(a_in_ready), 32'd0);
    step();
    check("t1_done_one_cycle", 32'(a_done), 32'd0);
    check("t1_words_hold", 32'(a_words_written), 32'd3);
    a_read(4'd2, 16'h2211, "t1_mem2");
    a_read(4'd3, 16'h4433, "t1_mem3");
    a_read(4'd4, 16'h6655, "t1_mem4");

    // backpressure gaps: in_valid 1,0,0,1 between bytes
    a_begin(4'd5, 5'd3);
    for (int i = 0; i < 6; i++) begin
      if (i != 0) begin
        step();
        check("t2_gap_busy", 32'(a_busy), 32'd1);
        step();
        check("t2_gap_busy", 32'(a_busy), 32'd1);
      end
      a_send(pat[i]);
    end
    check("t2_done", 32'(a_done), 32'd1);
    check("t2_words", 32'(a_words_written), 32'd3);
    step();
    a_read(4'd5, 16'h2211, "t2_mem5");
    a_read(4'd6, 16'h4433, "t2_mem6");
    a_read(4'd7, 16'h6655, "t2_mem7");
    a_read(4'd4, 16'h6655, "t2_mem4_untouched");

    // zero-length load
    a_begin(4'd5, 5'd0);
    check("t4_done", 32'(a_done), 32'd1);
    check("t4_in_ready", 32'(a_in_ready), 32'd0);
    check("t4_busy", 32'(a_busy), 32'd0);
    check("t4_words", 32'(a_words_written), 32'd0);
    step();
    check("t4_done_clear", 32'(a_done), 32'd0);
    check("t4_in_ready_after", 32'(a_in_ready), 32'd0);
    a_read(4'd5, 16'h2211, "t4_mem5_unchanged");

    // abort together with the last byte of the second word
    a_begin(4'd3, 5'd2);
    a_send(8'h01);
    a_send(8'h02);
    check("t5_words_one", 32'(a_words_written), 32'd1);
    a_send(8'h03);
    a_abort = 1'b1;
    a_in_valid = 1'b1;
    a_in_data = 8'h04;
    step();
    a_abort = 1'b0;
    a_in_valid = 1'b0;
    check("t5_busy", 32'(a_busy), 32'd0);
    check("t5_in_ready", 32'(a_in_ready), 32'd0);
    check("t5_no_done", 32'(a_done), 32'd0);
    check("t5_words", 32'(a_words_written), 32'd1);
    step();
    check("t5_no_done_later", 32'(a_done), 32'd0);
    a_read(4'd3, 16'h0201, "t5_mem3");
    a_read(4'd4, 16'h6655, "t5_mem4_unchanged");

    // address wrap on the 8-bit instance
    b_start = 1'b1;
    b_start_addr = 4'd14;
    b_load_words = 5'd4;
    step();
    b_start = 1'b0;
    b_in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b_in_data = 8'hA0 + 8'(i);
      step();
    end
    b_in_valid = 1'b0;
    check("t3_done", 32'(b_done), 32'd1);
    check("t3_words", 32'(b_words_written), 32'd4);
    b_rd_ena = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b_rd_addr = wrap_addr[i];
      step();
      check("t3_wrap_mem", 32'(b_rd_dout), 32'hA0 + 32'(i));
    end
    b_rd_ena = 1'b0;

    // asynchronous reset in the middle of a word
    a_begin(4'd10, 5'd2);
    a_send(8'hAA);
    check("t6_busy_pre", 32'(a_busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("t6_async_in_ready", 32'(a_in_ready), 32'd0);
    check("t6_async_busy", 32'(a_busy), 32'd0);
    check("t6_async_rd_dout", 32'(a_rd_dout), 32'd0);
    check("t6_async_words", 32'(a_words_written), 32'd0);
    #2;
    rst = 1'b0;
    step();
    a_begin(4'd10, 5'd2);
    a_send(8'hBE);
    a_send(8'hEF);
    a_send(8'hCA);
    a_send(8'hFE);
    check("t6_done", 32'(a_done), 32'd1);
    step();
    a_rd_ena = 1'b1;
    a_rd_addr = 4'd10;
    step();
    check("t6_rd_mem10", 32'(a_rd_dout), 32'h0000EFBE);
    a_rd_addr = 4'd11;
    step();
    check("t6_rd_mem11", 32'(a_rd_dout), 32'h0000FECA);
    a_rd_ena = 1'b0;
    a_rd_addr = 4'd10;
    step();
    check("t6_rd_hold", 32'(a_rd_dout), 32'h0000FECA);

    // read and write of the same address on the same edge
    a_begin(4'd10, 5'd1);
    a_send(8'h77);
    a_in_valid = 1'b1;
    a_in_data = 8'h88;
    a_rd_ena = 1'b1;
    a_rd_addr = 4'd10;
    step();
    a_in_valid = 1'b0;
    check("t7_collision_old", 32'(a_rd_dout), 32'h0000EFBE);
    check("t7_done", 32'(a_done), 32'd1);
    step();
    check("t7_new_data", 32'(a_rd_dout), 32'h00008877);
    a_rd_ena = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ram_loader.md
Name: ram_loader

Overview:
- Writer-side counterpart to the system's file-initialised ROMs: accepts a byte stream, e.g. a boot image arriving over a serial link or debug port.
- Packs bytes little-endian into DATA_W words, the same byte order the ROM images use: byte k of a word occupies bits k*8 upward.
- Writes the packed words into internal RAM from a programmable start address.
- Exposes a registered read port so the Z80 bus can fetch the loaded image.

Parameters:
- ADDR_W, 10, word address width; memory depth 2**ADDR_W words.
- DATA_W, 8, word width in bits (≥1); BPW = ((DATA_W-1)/8)+1 bytes per word.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a load; honoured only in IDLE.
- start_addr  in  ADDR_W  first word address written, sampled with start.
- load_words  in  ADDR_W+1  number of words to load, sampled with start.
- abort  in  1  cancel an active load.
- in_valid  in  1  byte available.
- in_data  in  8  byte value.
- in_ready  out  1  loader accepts byte this cycle.
- busy  out  1  high in LOAD.
- done  out  1  one-cycle pulse when all words are written.
- words_written  out  ADDR_W+1  words committed in current/last load.
- rd_ena  in  1  read enable.
- rd_addr  in  ADDR_W  read word address.
- rd_dout  out  DATA_W  registered read data.

Behaviour:
- Reset (async assert): state IDLE, in_ready 0, busy 0, done 0, words_written 0, rd_dout 0, byte index 0, assembly register 0. Memory contents are not reset.
- States: IDLE, LOAD, DONE.
- IDLE + start:
  - load_words == 0: go to DONE. No writes; words_written cleared to 0.
  - otherwise: latch address, count and target; clear words_written and byte index; go to LOAD.
- LOAD:
  - in_ready = 1 and busy = 1. A byte is accepted on any edge with in_valid & in_ready.
  - For each accepted byte that is not the last of its word, store it in assembly lane [idx*8 +: 8] and increment idx.
  - On the byte with idx == BPW-1:
    - Write mem[addr] on the same edge, using the assembled lanes plus in_data in the top lane.
    - Bits above DATA_W are discarded (DATA_W not a multiple of 8).
    - Reset idx to 0, increment addr, increment words_written.
  - After the write, if words_written reaches load_words, go to DONE.
- Address wrap: addr increments modulo 2**ADDR_W. If load_words exceeds the depth, later words overwrite earlier ones with no error.
- DONE: lasts one cycle; done = 1, in_ready = 0; then IDLE. words_written holds its final value until the next start.
- abort:
  - In LOAD, abort has priority over a simultaneous byte acceptance: that byte is dropped and nothing is written.
  - A partially assembled word is discarded; completed words remain in memory.
  - Go to IDLE with no done pulse; words_written holds the committed count.
  - In IDLE or DONE, abort is ignored.
- start while in LOAD or DONE is ignored.
- Read port:
  - rd_ena = 1 gives rd_dout <= mem[rd_addr] on the next edge (1-cycle latency).
  - rd_ena = 0 holds rd_dout.
  - Reads are legal in any state.
  - Same-address read and write on the same edge returns the old data.
- in_ready is a registered state decode. It never depends combinationally on in_valid.

Test Plan:
- Basic packing (DATA_W=16, ADDR_W=4):
  - start with start_addr=2, load_words=3.
  - Stream bytes 11,22,33,44,55,66 with in_valid held high.
  - Expected: mem[2]=2211, mem[3]=4433, mem[4]=6655; done pulses for exactly one cycle after the 6th byte; words_written=3.
- Backpressure gaps:
  - Same load with in_valid toggling 1,0,0,1 between bytes.
  - Expected: identical memory contents; busy stays high throughout; no extra writes.
- Wrap-around:
  - DATA_W=8, start_addr=14, load_words=4, bytes A0..A3.
  - Expected: mem[14]=A0, mem[15]=A1, mem[0]=A2, mem[1]=A3.
- Zero-length load:
  - load_words=0.
  - Expected: done on the next cycle; in_ready never asserted; memory unchanged; words_written=0.
- Abort mid-word:
  - DATA_W=16, load_words=2. Send 01,02,03, then raise abort together with byte 04.
  - Expected: mem[base]=0201; mem[base+1] unchanged; no done pulse; words_written=1; state IDLE.
- Async reset during LOAD, then read-back:
  - Assert rst mid-byte. Expected: in_ready and busy fall immediately without waiting for a clock edge; rd_dout=0.
  - After release, start a new load, then read each address with rd_ena. Expected: data appears one cycle after rd_addr.
  - Same-address read/write collision. Expected: the read returns the pre-write value.
